// File: rtl/ad9253_spi_pkg.sv
// Shared constants and types for the AD9253 3-wire SPI responder.
package ad9253_spi_pkg;

    localparam int unsigned DEF_ADDR_W = 13;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned INSTR_W    = 16;

    localparam int unsigned RW_BIT = 15;
    localparam int unsigned W_MSB  = 14;
    localparam int unsigned W_LSB  = 13;

    localparam logic [1:0] W_STREAM   = 2'b11;
    localparam logic [1:0] BUDGET_W00 = 2'd1;
    localparam logic [1:0] BUDGET_W01 = 2'd2;
    localparam logic [1:0] BUDGET_W10 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_e;

    // Streaming (W=11) has no budget; the caller tracks it with a separate flag.
    function automatic logic [1:0] w_to_budget(input logic [1:0] w);
        case (w)
            2'b00:   return BUDGET_W00;
            2'b01:   return BUDGET_W01;
            2'b10:   return BUDGET_W10;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ad9253_spi_slave_sync.sv
// Multi-stage synchroniser with rise/fall detect on the last stage against one delay flop.
module ad9253_spi_slave_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic valid_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        dly_d  = sync_q[SYNC_STAGES-1];
        vld_d  = {vld_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
            vld_q  <= '0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            vld_q  <= vld_d;
        end
    end

    // valid_o rises once the last stage holds a real pin sample instead of the reset value.
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~dly_q;
    assign fall_o  = ~level_o & dly_q;
    assign valid_o = vld_q[SYNC_STAGES-1];

endmodule

// File: rtl/ad9253_spi_slave.sv
// AD9253 3-wire SPI responder, all pins oversampled in the clk domain.
// Optional saturating frame-error counter: define AD9253_SPI_SLAVE_ERRCNT_EN.
module ad9253_spi_slave
    import ad9253_spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_csn,
    input  logic              spi_clk,
    input  logic              sdio_i,
    output logic              sdio_o,
    output logic              sdio_oe,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_busy
`ifdef AD9253_SPI_SLAVE_ERRCNT_EN
    ,
    output logic [7:0]        frame_err_cnt
`endif
);

    logic csn_lvl, csn_rise, csn_fall, csn_vld;
    logic sclk_lvl_unused, sclk_rise, sclk_fall, sclk_vld;
    logic sdio_lvl, sdio_rise_unused, sdio_fall_unused, sdio_vld;

    ad9253_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .clk(clk), .rst_n(rst_n), .d_i(spi_csn),
        .level_o(csn_lvl), .rise_o(csn_rise), .fall_o(csn_fall), .valid_o(csn_vld)
    );
    ad9253_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .d_i(spi_clk),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall), .valid_o(sclk_vld)
    );
    ad9253_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdio_sync (
        .clk(clk), .rst_n(rst_n), .d_i(sdio_i),
        .level_o(sdio_lvl), .rise_o(sdio_rise_unused), .fall_o(sdio_fall_unused), .valid_o(sdio_vld)
    );

    state_e              state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [INSTR_W-1:0]  shift_q, shift_d, shift_in;
    logic [ADDR_W-1:0]   addr_q, addr_d, addr_out_q, addr_out_d;
    logic [1:0]          budget_q, budget_d;
    logic                stream_q, stream_d;
    logic [DATA_W-1:0]   load_q, load_d, out_q, out_d, wdata_q, wdata_d;
    logic                sdio_o_q, sdio_o_d, sdio_oe_q, sdio_oe_d;
    logic                wr_en_q, wr_en_d, rd_en_q, rd_en_d, rd_cap_q, rd_cap_d;
    logic                busy_q, busy_d, armed_q, armed_d;
    logic                abort;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        budget_d   = budget_q;
        stream_d   = stream_q;
        load_d     = rd_cap_q ? reg_rdata : load_q;
        out_d      = out_q;
        sdio_o_d   = sdio_o_q;
        sdio_oe_d  = sdio_oe_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        addr_out_d = addr_out_q;
        wdata_d    = wdata_q;
        rd_cap_d   = rd_en_q;
        // A CSN that is already low when reset releases must not look like a frame start.
        armed_d    = armed_q | (csn_vld & sclk_vld & sdio_vld & csn_lvl);
        abort      = 1'b0;
        shift_in   = {shift_q[INSTR_W-2:0], sdio_lvl};

        if (csn_rise) begin
            state_d   = ST_IDLE;
            sdio_oe_d = 1'b0;
            abort     = (state_q == ST_INSTR) ||
                        (((state_q == ST_WDATA) || (state_q == ST_RDATA)) && (bit_cnt_q != '0));
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (csn_fall && armed_q) begin
                        bit_cnt_d = '0;
                        state_d   = ST_INSTR;
                    end
                end
                ST_INSTR: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(INSTR_W - 1)) begin
                            bit_cnt_d = '0;
                            addr_d    = shift_in[ADDR_W-1:0];
                            stream_d  = (shift_in[W_MSB:W_LSB] == W_STREAM);
                            budget_d  = w_to_budget(shift_in[W_MSB:W_LSB]);
                            if (shift_in[RW_BIT]) begin
                                state_d    = ST_RDATA;
                                rd_en_d    = 1'b1;
                                addr_out_d = shift_in[ADDR_W-1:0];
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(DATA_W - 1)) begin
                            bit_cnt_d  = '0;
                            wr_en_d    = 1'b1;
                            addr_out_d = addr_q;
                            wdata_d    = shift_in[DATA_W-1:0];
                            addr_d     = addr_q - ADDR_W'(1);
                            if (!stream_q) begin
                                budget_d = budget_q - 2'd1;
                                if (budget_q == 2'd1) state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        sdio_oe_d = 1'b1;
                        if (bit_cnt_q == '0) begin
                            sdio_o_d = load_q[DATA_W-1];
                            out_d    = {load_q[DATA_W-2:0], 1'b0};
                        end else begin
                            sdio_o_d = out_q[DATA_W-1];
                            out_d    = {out_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'(DATA_W - 1)) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q - ADDR_W'(1);
                            if (stream_q || (budget_q != 2'd1)) begin
                                if (!stream_q) budget_d = budget_q - 2'd1;
                                rd_en_d    = 1'b1;
                                addr_out_d = addr_q - ADDR_W'(1);
                            end else begin
                                state_d   = ST_DONE;
                                sdio_oe_d = 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: sdio_oe_d = 1'b0;
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            budget_q   <= '0;
            stream_q   <= 1'b0;
            load_q     <= '0;
            out_q      <= '0;
            sdio_o_q   <= 1'b0;
            sdio_oe_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_cap_q   <= 1'b0;
            addr_out_q <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            budget_q   <= budget_d;
            stream_q   <= stream_d;
            load_q     <= load_d;
            out_q      <= out_d;
            sdio_o_q   <= sdio_o_d;
            sdio_oe_q  <= sdio_oe_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            rd_cap_q   <= rd_cap_d;
            addr_out_q <= addr_out_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            armed_q    <= armed_d;
        end
    end

    assign sdio_o     = sdio_o_q;
    assign sdio_oe    = sdio_oe_q;
    assign reg_wr_en  = wr_en_q;
    assign reg_rd_en  = rd_en_q;
    assign reg_addr   = addr_out_q;
    assign reg_wdata  = wdata_q;
    assign frame_busy = busy_q;

`ifdef AD9253_SPI_SLAVE_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (abort && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign frame_err_cnt = err_cnt_q;
`else
    logic abort_unused;
    assign abort_unused = abort;
`endif

endmodule

// File: tb/tb_ad9253_spi_slave.sv
// Table-driven bench for ad9253_spi_slave acting as a bit-banged SPI master.
// Define AD9253_SPI_SLAVE_ERRCNT_EN to also check frame_err_cnt.
module tb_ad9253_spi_slave;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n, spi_csn, spi_clk, sdio_i;
    logic        sdio_o, sdio_oe, reg_wr_en, reg_rd_en, frame_busy;
    logic [12:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = 8'h00;
`ifdef AD9253_SPI_SLAVE_ERRCNT_EN
    logic [7:0]  frame_err_cnt;
`endif

    ad9253_spi_slave #(.ADDR_W(13), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi_csn(spi_csn), .spi_clk(spi_clk),
        .sdio_i(sdio_i), .sdio_o(sdio_o), .sdio_oe(sdio_oe),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .frame_busy(frame_busy)
`ifdef AD9253_SPI_SLAVE_ERRCNT_EN
        , .frame_err_cnt(frame_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      instr;
        logic [31:0]      data;
        int               nbits;
        int               nwr;
        int               nrd;
        int               nrx;
        logic [2:0][12:0] ea;
        logic [2:0][7:0]  ed;
        logic             eoe;
    } vec_t;

    vec_t tbl [10];

    int n_vec = 0;
    int n_mis = 0;
    int wr_cnt = 0, rd_cnt = 0, strobe_viol = 0;
    logic oe_seen = 1'b0;
    logic prev_wr = 1'b0, prev_rd = 1'b0;
    logic [12:0] wr_a [4];
    logic [7:0]  wr_d [4];
    logic [12:0] rd_a [4];

    function automatic logic [7:0] model_rd(input logic [12:0] a);
        case (a)
            13'h0001: return 8'hA5;
            13'h0000: return 8'h5A;
            13'h1FFF: return 8'hC3;
            default:  return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    // Synchronous register file: data valid the cycle after the read request.
    always @(posedge clk) if (reg_rd_en) reg_rdata <= model_rd(reg_addr);

    always @(negedge clk) begin
        if (reg_wr_en) begin
            if (wr_cnt < 4) begin wr_a[wr_cnt] = reg_addr; wr_d[wr_cnt] = reg_wdata; end
            wr_cnt++;
        end
        if (reg_rd_en) begin
            if (rd_cnt < 4) rd_a[rd_cnt] = reg_addr;
            rd_cnt++;
        end
        if ((reg_wr_en && reg_rd_en) || ((reg_wr_en || reg_rd_en) && (prev_wr || prev_rd)))
            strobe_viol++;
        prev_wr = reg_wr_en;
        prev_rd = reg_rd_en;
        if (sdio_oe) oe_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] instr, input logic [31:0] data, input int nbits,
                                input int nwr, input int nrd, input int nrx,
                                input logic [12:0] a0, input logic [12:0] a1, input logic [12:0] a2,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                input logic eoe);
        vec_t v;
        v.instr = instr; v.data = data; v.nbits = nbits;
        v.nwr = nwr; v.nrd = nrd; v.nrx = nrx;
        v.ea = {a2, a1, a0};
        v.ed = {d2, d1, d0};
        v.eoe = eoe;
        return v;
    endfunction

    task automatic spi_bit(input logic b, output logic s);
        sdio_i = b;
        repeat (HALF) @(posedge clk);
        #1 spi_clk = 1'b1;
        s = sdio_o;
        repeat (HALF) @(posedge clk);
        #1 spi_clk = 1'b0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic        s;
        logic        b;
        logic [31:0] rx;
        rx = '0;
        wr_cnt = 0; rd_cnt = 0; oe_seen = 1'b0;
        spi_csn = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        for (int i = 0; i < v.nbits; i++) begin
            if (i < 16) b = v.instr[15-i];
            else        b = v.data[31-(i-16)];
            spi_bit(b, s);
            if (i >= 16 && i < 48) rx[31-(i-16)] = s;
            if (i == 0) check($sformatf("v%0d_busy_mid", k), frame_busy, 1);
        end
        repeat (HALF) @(posedge clk);
        #1 spi_csn = 1'b1;
        repeat (3) @(posedge clk);
        #1 check($sformatf("v%0d_oe_after_csn", k), sdio_oe, 0);
        repeat (8) @(posedge clk);
        #1 check($sformatf("v%0d_busy_end", k), frame_busy, 0);
        check($sformatf("v%0d_nwr", k), wr_cnt, v.nwr);
        check($sformatf("v%0d_nrd", k), rd_cnt, v.nrd);
        check($sformatf("v%0d_oe_seen", k), oe_seen, v.eoe);
        for (int j = 0; j < v.nwr && j < wr_cnt && j < 3; j++) begin
            check($sformatf("v%0d_wr%0d_addr", k, j), wr_a[j], v.ea[j]);
            check($sformatf("v%0d_wr%0d_data", k, j), wr_d[j], v.ed[j]);
        end
        for (int j = 0; j < v.nrd && j < rd_cnt && j < 3; j++)
            check($sformatf("v%0d_rd%0d_addr", k, j), rd_a[j], v.ea[j]);
        for (int j = 0; j < v.nrx; j++)
            check($sformatf("v%0d_rx%0d", k, j), rx[31-8*j -: 8], v.ed[j]);
    endtask

    initial begin
        logic        s;
        logic [23:0] word;

        rst_n = 1'b0; spi_csn = 1'b1; spi_clk = 1'b0; sdio_i = 1'b0;

        //            instr     data          bits wr rd rx  a0       a1       a2       d0     d1     d2    oe
        tbl[0] = mk(16'h0008, 32'h03000000, 24, 1, 0, 0, 13'h008, 13'h000, 13'h000, 8'h03, 8'h00, 8'h00, 0);
        tbl[1] = mk(16'h8001, 32'h00000000, 24, 0, 1, 1, 13'h001, 13'h000, 13'h000, 8'hA5, 8'h00, 8'h00, 1);
        tbl[2] = mk(16'h2015, 32'h1122FF00, 40, 2, 0, 0, 13'h015, 13'h014, 13'h000, 8'h11, 8'h22, 8'h00, 0);
        tbl[3] = mk(16'hA000, 32'h00000000, 32, 0, 2, 2, 13'h000, 13'h1FFF, 13'h000, 8'h5A, 8'hC3, 8'h00, 1);
        tbl[4] = mk(16'h0008, 32'h30000000, 20, 0, 0, 0, 13'h000, 13'h000, 13'h000, 8'h00, 8'h00, 8'h00, 0);
        tbl[5] = mk(16'h4100, 32'h01020300, 40, 3, 0, 0, 13'h100, 13'h0FF, 13'h0FE, 8'h01, 8'h02, 8'h03, 0);
        tbl[6] = mk(16'h6010, 32'hAABBCC00, 40, 3, 0, 0, 13'h010, 13'h00F, 13'h00E, 8'hAA, 8'hBB, 8'hCC, 0);
        tbl[7] = mk(16'h8123, 32'h00000000, 24, 0, 1, 1, 13'h123, 13'h000, 13'h000, 8'h1F, 8'h00, 8'h00, 1);
        tbl[8] = mk(16'h8001, 32'h00000000, 10, 0, 0, 0, 13'h000, 13'h000, 13'h000, 8'h00, 8'h00, 8'h00, 0);
        tbl[9] = mk(16'h8001, 32'h00000000, 20, 0, 1, 0, 13'h001, 13'h000, 13'h000, 8'h00, 8'h00, 8'h00, 1);

        repeat (5) @(posedge clk);
        #1;
        check("rst_sdio_o", sdio_o, 0);
        check("rst_sdio_oe", sdio_oe, 0);
        check("rst_strobes", {reg_wr_en, reg_rd_en}, 0);
        check("rst_addr_wdata", {reg_addr, reg_wdata}, 0);
        check("rst_busy", frame_busy, 0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        for (int k = 0; k < 10; k++) run_vec(k, tbl[k]);

        // CSN rise detected together with the 8th data rise: the byte is discarded.
        word = 24'h00085A;
        wr_cnt = 0;
        spi_csn = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        for (int i = 0; i < 23; i++) spi_bit(word[23-i], s);
        sdio_i = word[0];
        repeat (HALF) @(posedge clk);
        #1 spi_clk = 1'b1; spi_csn = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 spi_clk = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("simul_csn_sclk_nwr", wr_cnt, 0);
        check("simul_csn_sclk_busy", frame_busy, 0);
`ifdef AD9253_SPI_SLAVE_ERRCNT_EN
        check("err_cnt_aborts", frame_err_cnt, 4);
`endif

        // Reset pulsed during RDATA bit 4, CSN held low afterwards.
        word = 24'h800100;
        spi_csn = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) spi_bit(word[23-i], s);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_sdio_oe", sdio_oe, 0);
        check("midrst_strobes", {reg_wr_en, reg_rd_en}, 0);
        check("midrst_addr", reg_addr, 0);
        check("midrst_busy", frame_busy, 0);
        rst_n = 1'b1;
        wr_cnt = 0; rd_cnt = 0; oe_seen = 1'b0;
        word = 24'h000803;
        for (int i = 0; i < 24; i++) spi_bit(word[23-i], s);
        check("postrst_nwr", wr_cnt, 0);
        check("postrst_nrd", rd_cnt, 0);
        check("postrst_oe", oe_seen, 0);
        check("postrst_busy", frame_busy, 0);
        repeat (HALF) @(posedge clk);
        #1 spi_csn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
`ifdef AD9253_SPI_SLAVE_ERRCNT_EN
        check("err_cnt_after_rst", frame_err_cnt, 0);
`endif
        run_vec(10, tbl[0]);
        run_vec(11, tbl[1]);

        check("strobe_rules", strobe_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
